// File: rtl/lcd_bus_arbiter.sv
// rtl/lcd_bus_arbiter.sv - two-requester HD44780 bus arbiter that owns all LCD bus timing
module lcd_bus_arbiter #(
    parameter int CNT_W          = 32,
    parameter int POWERON_CYC    = 1000000,
    parameter int SETUP_CYC      = 2000,
    parameter int EN_CYC         = 50,
    parameter int EXEC_CYC       = 2000,
    parameter int CLEAR_EXEC_CYC = 100000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  req_valid,
    input  logic [1:0]  req_rs,
    input  logic [15:0] req_data,
    input  logic [1:0]  req_lock,
    output logic [1:0]  req_ready,
    output logic [1:0]  req_done,
    output logic        owner,
    output logic        init_done,
    output logic [7:0]  lcd_data,
    output logic        lcd_rs,
    output logic        lcd_en,
    output logic        lcd_rw,
    output logic        lcd_on,
    output logic        lcd_blon
);

    typedef enum logic [2:0] {
        ST_POWER_ON,
        ST_IDLE,
        ST_SETUP,
        ST_EN_HIGH,
        ST_EXEC
    } state_t;

    // Terminal counts: each phase leaves when the counter reaches N-1
    localparam logic [CNT_W-1:0] L_POWERON_LAST = CNT_W'(POWERON_CYC - 1);
    localparam logic [CNT_W-1:0] L_SETUP_LAST   = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] L_EN_LAST      = CNT_W'(EN_CYC - 1);
    localparam logic [CNT_W-1:0] L_EXEC_LAST    = CNT_W'(EXEC_CYC - 1);
    localparam logic [CNT_W-1:0] L_CLEAR_LAST   = CNT_W'(CLEAR_EXEC_CYC - 1);

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_last_grant;
    logic             r_lock;
    logic             r_long;
    logic             r_owner;
    logic             r_init_done;
    logic             r_en;
    logic             r_rs;
    logic [7:0]       r_data;
    logic [1:0]       r_done;

    logic             w_grant;
    logic             w_grant_ok;
    logic             w_xfer;
    logic             w_sel_rs;
    logic             w_sel_lock;
    logic [7:0]       w_sel_data;
    logic [CNT_W-1:0] w_exec_last;

    // Choose the requester eligible this cycle: locked owner, else round-robin
    always_comb begin
        w_grant    = 1'b0;
        w_grant_ok = 1'b0;
        if (r_lock) begin
            w_grant    = r_owner;
            w_grant_ok = req_valid[r_owner];
        end else if (req_valid == 2'b11) begin
            w_grant    = ~r_last_grant;
            w_grant_ok = 1'b1;
        end else if (req_valid[1]) begin
            w_grant    = 1'b1;
            w_grant_ok = 1'b1;
        end else if (req_valid[0]) begin
            w_grant    = 1'b0;
            w_grant_ok = 1'b1;
        end
    end

    assign w_xfer      = (r_state == ST_IDLE) && w_grant_ok;
    assign req_ready   = w_xfer ? (w_grant ? 2'b10 : 2'b01) : 2'b00;
    assign w_sel_rs    = req_rs[w_grant];
    assign w_sel_lock  = req_lock[w_grant];
    assign w_sel_data  = w_grant ? req_data[15:8] : req_data[7:0];
    // Clear/home commands need the much longer execution wait
    assign w_exec_last = r_long ? L_CLEAR_LAST : L_EXEC_LAST;

    // Bus sequencer: power-on wait, grant, setup, enable pulse, execution wait
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_POWER_ON;
            r_cnt        <= '0;
            r_last_grant <= 1'b1;
            r_lock       <= 1'b0;
            r_long       <= 1'b0;
            r_owner      <= 1'b0;
            r_init_done  <= 1'b0;
            r_en         <= 1'b0;
            r_rs         <= 1'b0;
            r_data       <= 8'h00;
            r_done       <= 2'b00;
        end else begin
            r_done <= 2'b00;
            case (r_state)
                ST_POWER_ON: begin
                    if (r_cnt == L_POWERON_LAST) begin
                        r_cnt       <= '0;
                        r_init_done <= 1'b1;
                        r_state     <= ST_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_IDLE: begin
                    if (w_xfer) begin
                        r_rs         <= w_sel_rs;
                        r_data       <= w_sel_data;
                        r_owner      <= w_grant;
                        r_last_grant <= w_grant;
                        r_lock       <= w_sel_lock;
                        r_long       <= ~w_sel_rs && (w_sel_data[7:2] == 6'd0);
                        r_cnt        <= '0;
                        r_state      <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    if (r_cnt == L_SETUP_LAST) begin
                        r_cnt   <= '0;
                        r_en    <= 1'b1;
                        r_state <= ST_EN_HIGH;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_EN_HIGH: begin
                    if (r_cnt == L_EN_LAST) begin
                        r_cnt   <= '0;
                        r_en    <= 1'b0;
                        r_state <= ST_EXEC;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_EXEC: begin
                    if (r_cnt == w_exec_last) begin
                        r_cnt   <= '0;
                        r_done  <= r_owner ? 2'b10 : 2'b01;
                        r_state <= ST_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_cnt   <= '0;
                    r_en    <= 1'b0;
                    r_state <= ST_POWER_ON;
                end
            endcase
        end
    end

    assign req_done  = r_done;
    assign owner     = r_owner;
    assign init_done = r_init_done;
    assign lcd_data  = r_data;
    assign lcd_rs    = r_rs;
    assign lcd_en    = r_en;
    assign lcd_rw    = 1'b0;
    assign lcd_on    = 1'b1;
    assign lcd_blon  = 1'b1;

endmodule

// File: doc/lcd_bus_arbiter.md
Name: lcd_bus_arbiter

Overview:
- Shares the single HD44780 character-LCD bus between two byte-write requesters: requester 0 writes page/menu text, requester 1 writes the live frequency digits.
- Owns all HD44780 bus timing: power-on wait, setup, enable pulse and execution wait. Requesters therefore only present {rs, data} with a valid/ready handshake.
- Arbitrates round-robin between the requesters. A lock lets one requester write a multi-byte sequence (cursor command plus digits) without interleaving.
- Sits between the menu/page FSM, the frequency display FSM and the board LCD pins.

Parameters:
- CNT_W, 32, width of the phase counter.
- POWERON_CYC, 1000000, cycles to wait after reset before the first grant (20 ms at 50 MHz).
- SETUP_CYC, 2000, cycles rs/data are stable with en low before the enable pulse.
- EN_CYC, 50, cycles en is held high.
- EXEC_CYC, 2000, post-pulse wait for normal commands and data (40 us).
- CLEAR_EXEC_CYC, 100000, post-pulse wait for clear/home commands (2 ms).

Ports:
- clk  in  1  system clock, 50 MHz
- reset  in  1  synchronous, active-high reset
- req_valid  in  2  per-requester write request; bit k belongs to requester k
- req_rs  in  2  per-requester register select: 0 = command, 1 = data
- req_data  in  16  per-requester byte; [7:0] for requester 0, [15:8] for requester 1
- req_lock  in  2  keep the bus after this transfer
- req_ready  out  2  transfer accepted this cycle (combinational)
- req_done  out  2  one-cycle pulse when the accepted byte's execution wait ends
- owner  out  1  index of the last granted requester
- init_done  out  1  power-on wait complete
- lcd_data  out  8  LCD data bus
- lcd_rs  out  1  LCD register select
- lcd_en  out  1  LCD enable
- lcd_rw  out  1  tied to 0
- lcd_on  out  1  tied to 1
- lcd_blon  out  1  tied to 1

Behaviour:
- States: POWER_ON, IDLE, SETUP, EN_HIGH, EXEC. All are registered, single clock domain.
- Reset (synchronous, in any state, including mid-transfer):
  - state <= POWER_ON, counter <= 0.
  - lcd_en = 0, lcd_rs = 0, lcd_data = 0x00 from the next edge.
  - req_done = 0, owner = 0, init_done = 0, lock flag cleared, last_grant = 1, so requester 0 wins the first tie.
- POWER_ON:
  - Counts POWERON_CYC cycles.
  - Then init_done <= 1 (stays 1 until reset) and moves to IDLE.
  - req_ready = 0 throughout.
- IDLE, grant selection:
  - Lock flag set: only the locked owner is eligible.
  - Lock flag clear and one valid requester: that requester is granted.
  - Lock flag clear and both valid: the requester other than last_grant is granted.
  - req_ready[g] = 1 only when state == IDLE, g is granted and req_valid[g] = 1.
- On transfer (valid & ready):
  - Latch rs and data into the output registers.
  - owner <= g, last_grant <= g, lock flag <= req_lock[g].
  - Set the long-wait flag if rs == 0 and data[7:2] == 0 (commands 0x01/0x02/0x03).
  - Move to SETUP.
- SETUP: en = 0 for exactly SETUP_CYC cycles. EN_HIGH: en = 1 for exactly EN_CYC cycles. EXEC: en = 0 for EXEC_CYC cycles, or CLEAR_EXEC_CYC if the long-wait flag is set.
- Phase counters: the counter resets to 0 on each phase entry; exit on counter == N-1. Every parameter must be ≥ 1.
- Completion: on the edge leaving EXEC, req_done[owner] pulses high for 1 cycle, concurrent with state == IDLE. A new grant may occur in that same cycle.
- Latency: transfer at cycle t → en high during cycles t+S+1 .. t+S+E → req_done at t+S+E+X+1. Back-to-back bytes therefore cost S+E+X+1 cycles.
- lcd_rs and lcd_data hold the last written byte while in IDLE. They are never changed outside IDLE.
- Lock held but the owner's valid is low: stay in IDLE. The other requester stalls; there is no timeout.
- A requester may drop valid without a transfer. Only valid & ready commits a byte.

Test Plan:
(Parameters overridden: POWERON=5, SETUP=2, EN=3, EXEC=4, CLEAR_EXEC=10.)
- Power-on: reset high 2 cycles, then both requests valid → req_ready stays 0 for 5 cycles; init_done rises; requester 0 is granted first.
- Single data byte (rs = 1, data = 0x48) from requester 1 accepted at cycle t → lcd_en high during t+3..t+5; req_done[1] pulses at t+10; lcd_data = 0x48 and lcd_rs = 1 throughout.
- Clear command (rs = 0, data = 0x01) → EXEC lasts 10 cycles, so req_done arrives at t+16. The same test with 0xC0 → req_done at t+10.
- Both valid continuously, no locks → grants alternate 0,1,0,1; each transfer completes before the next grant.
- Requester 1 sends 0xC0 with lock = 1, then six digits (lock = 1 on the first five, 0 on the last) while requester 0 is valid throughout → all 7 bytes go to requester 1 contiguously, then requester 0 is granted.
- Reset asserted during EN_HIGH → lcd_en = 0 on the next edge; no req_done pulse; the power-on wait repeats.
